// File: rtl/tracer_pkg.sv
// Shared types and defaults for the RVFI retirement sequencer.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package tracer_pkg;

    localparam int unsigned DEPTH_DEFAULT = 16;
    localparam int unsigned REC_W_DEFAULT = 256;
    localparam int unsigned CMT_W_DEFAULT = 128;
    localparam int unsigned PL_W          = 5;

    typedef logic [PL_W-1:0] pl_t;

    // Full logical trace entry at default widths. The sequencer stores the
    // wide rec/cmt fields in separate parameterised arrays and keeps the
    // narrow control fields together in entry_meta_t; done lives in its own
    // resettable vector so that flush and reset can clear it in one cycle.
    typedef struct packed {
        logic [REC_W_DEFAULT-1:0] rec;
        logic                     is_ex;
        pl_t                      pl;
        logic                     done;
        logic [CMT_W_DEFAULT-1:0] cmt;
    } trace_entry_t;

    typedef struct packed {
        logic is_ex;
        pl_t  pl;
    } entry_meta_t;

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/rvfi_exq_fifo.sv
// Queue of FIFO slot indices of EX entries awaiting commit, in issue order.
// Latency: a pushed index is visible at head0_o/head1_o the cycle after push.
// Backpressure: none; the parent bounds occupancy to Depth, pops never exceed count_o.
//
// Ports: clk_i/rst_ni (async, active-high), flush_i empties the queue;
//        push_cnt_i (0..2) writes push_idx0_i then push_idx1_i;
//        pop_cnt_i (0..2) drops that many from the head;
//        head0_o/head1_o are the two oldest indices, count_o the occupancy.
module rvfi_exq_fifo
    import tracer_pkg::*;
#(
    parameter int unsigned Depth = DEPTH_DEFAULT,
    parameter int unsigned IdxW  = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [1:0]      push_cnt_i,
    input  logic [IdxW-1:0] push_idx0_i,
    input  logic [IdxW-1:0] push_idx1_i,
    input  logic [1:0]      pop_cnt_i,
    output logic [IdxW-1:0] head0_o,
    output logic [IdxW-1:0] head1_o,
    output logic [IdxW:0]   count_o
);
    localparam int unsigned PW = IdxW + 1;

    logic [IdxW-1:0] mem [Depth];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [IdxW-1:0] wr_slot0, wr_slot1, rd_slot0, rd_slot1;

    always_comb begin
        wr_slot0 = wr_ptr_q[IdxW-1:0];
        wr_slot1 = wr_slot0 + IdxW'(1);
        rd_slot0 = rd_ptr_q[IdxW-1:0];
        rd_slot1 = rd_slot0 + IdxW'(1);
        wr_ptr_d = wr_ptr_q + PW'(push_cnt_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Index storage is not reset; only entries between the pointers are read.
    always_ff @(posedge clk_i) begin
        if (push_cnt_i != 2'd0) mem[wr_slot0] <= push_idx0_i;
        if (push_cnt_i == 2'd2) mem[wr_slot1] <= push_idx1_i;
    end

    assign head0_o = mem[rd_slot0];
    assign head1_o = mem[rd_slot1];
    // Pointers wrap modulo 2*Depth, so the plain difference is the occupancy.
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/rvfi_retire_seq.sv
// In-order RVFI trace sequencer: records issue-side traces, merges out-of-order EX commits, retires in order.
// Latency: non-EX entry retirable the cycle after push; EX entry the cycle after its commit.
// Backpressure: iss_ready_o low when fewer than 2 free slots (pushes then dropped, err_o[0]); out_ready_i stalls head.
//
// Ports: clk_i, rst_ni (async, active-high despite the name), flush_i;
//        iss_*: 2-lane issue push (valid, is_ex, pl one-hot, record), iss_ready_o;
//        cmt_*: up to 2 EX commits per cycle (count, pl, completion data);
//        out_*: head record/completion data with valid/ready;
//        mismatch_o: registered pl-compare pulse; err_o: sticky {commit underflow, issue overflow}.
module rvfi_retire_seq
    import tracer_pkg::*;
#(
    parameter int unsigned Depth = DEPTH_DEFAULT,
    parameter int unsigned RecW  = REC_W_DEFAULT,
    parameter int unsigned CmtW  = CMT_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [1:0]      iss_valid_i,
    input  logic [1:0]      iss_is_ex_i,
    input  logic [4:0]      iss_pl0_i,
    input  logic [4:0]      iss_pl1_i,
    input  logic [RecW-1:0] iss_rec0_i,
    input  logic [RecW-1:0] iss_rec1_i,
    output logic            iss_ready_o,
    input  logic [1:0]      cmt_cnt_i,
    input  logic [4:0]      cmt_pl0_i,
    input  logic [4:0]      cmt_pl1_i,
    input  logic [CmtW-1:0] cmt_data0_i,
    input  logic [CmtW-1:0] cmt_data1_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [RecW-1:0] out_rec_o,
    output logic [CmtW-1:0] out_cmt_o,
    output logic            mismatch_o,
    output logic [1:0]      err_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = AW + 1;

    typedef logic [AW-1:0] idx_t;

    // Registered state
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [Depth-1:0] done_q, done_d;
    logic             mismatch_q, mismatch_d;
    logic [1:0]       err_q, err_d;

    // Entry storage, deliberately without reset
    logic [RecW-1:0]  rec_mem  [Depth];
    logic [CmtW-1:0]  cmt_mem  [Depth];
    entry_meta_t      meta_mem [Depth];

    logic             empty, full;
    logic             push_any, push_ok, ovf;
    logic [1:0]       push_lanes, n_push, ex_push;
    idx_t             slot0, slot1;
    logic [1:0]       cmt_req, cmt_avail, n_cmt, cmt_ok;
    logic             udf;
    logic [PW-1:0]    exq_count;
    idx_t             exq_head0, exq_head1;
    idx_t             exq_idx0;
    idx_t             head;
    logic             head_is_ex;
    logic             retire;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Two free slots are always demanded so a full 2-lane push never splits.
    assign iss_ready_o = ({1'b0, count_q} + (PW+1)'(2)) <= (PW+1)'(Depth);

    // ---------------- issue side ----------------
    always_comb begin
        push_any   = |iss_valid_i;
        push_ok    = push_any && iss_ready_o && !full && !flush_i;
        push_lanes = push_ok ? iss_valid_i : 2'b00;
        n_push     = popcnt2(push_lanes);
        slot0      = wr_ptr_q[AW-1:0];
        // A lone lane1 push takes the current write slot.
        slot1      = iss_valid_i[0] ? (slot0 + idx_t'(1)) : slot0;
        ovf        = push_any && !iss_ready_o && !flush_i;
        ex_push    = push_lanes & iss_is_ex_i;
        exq_idx0   = ex_push[0] ? slot0 : slot1;
    end

    // ---------------- commit side ----------------
    // Commits only draw on indices queued in earlier cycles (exq_count is
    // registered), so an entry pushed this cycle cannot be committed yet.
    always_comb begin
        cmt_req   = (cmt_cnt_i == 2'd3) ? 2'd2 : cmt_cnt_i;
        cmt_avail = (exq_count >= PW'(2)) ? 2'd2 : exq_count[1:0];
        n_cmt     = flush_i ? 2'd0 : min2(cmt_req, cmt_avail);
        udf       = !flush_i && (cmt_req > cmt_avail);
        cmt_ok    = {n_cmt == 2'd2, n_cmt != 2'd0};
        mismatch_d = (cmt_ok[0] && (meta_mem[exq_head0].pl != cmt_pl0_i)) ||
                     (cmt_ok[1] && (meta_mem[exq_head1].pl != cmt_pl1_i));
    end

    rvfi_exq_fifo #(
        .Depth (Depth),
        .IdxW  (AW)
    ) u_exq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_cnt_i  (popcnt2(ex_push)),
        .push_idx0_i (exq_idx0),
        .push_idx1_i (slot1),
        .pop_cnt_i   (n_cmt),
        .head0_o     (exq_head0),
        .head1_o     (exq_head1),
        .count_o     (exq_count)
    );

    // ---------------- retire side ----------------
    assign head        = rd_ptr_q[AW-1:0];
    assign head_is_ex  = meta_mem[head].is_ex;
    // done_q is registered, so a commit becomes retirable one cycle later.
    assign out_valid_o = !empty && (!head_is_ex || done_q[head]) && !flush_i;
    assign retire      = out_valid_o && out_ready_i;
    assign out_rec_o   = rec_mem[head];
    assign out_cmt_o   = head_is_ex ? cmt_mem[head] : '0;
    assign mismatch_o  = mismatch_q;
    assign err_o       = err_q;

    // ---------------- next state ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(n_push);
        rd_ptr_d = rd_ptr_q + PW'(retire);
        count_d  = count_q + PW'(n_push) - PW'(retire);
        done_d   = done_q;
        if (push_lanes[0]) done_d[slot0] = 1'b0;
        if (push_lanes[1]) done_d[slot1] = 1'b0;
        if (cmt_ok[0])     done_d[exq_head0] = 1'b1;
        if (cmt_ok[1])     done_d[exq_head1] = 1'b1;
        err_d = err_q | {udf, ovf};
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            done_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= '0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_lanes[0]) begin
            rec_mem[slot0]  <= iss_rec0_i;
            meta_mem[slot0] <= '{is_ex: iss_is_ex_i[0], pl: iss_pl0_i};
        end
        if (push_lanes[1]) begin
            rec_mem[slot1]  <= iss_rec1_i;
            meta_mem[slot1] <= '{is_ex: iss_is_ex_i[1], pl: iss_pl1_i};
        end
        if (cmt_ok[0]) cmt_mem[exq_head0] <= cmt_data0_i;
        if (cmt_ok[1]) cmt_mem[exq_head1] <= cmt_data1_i;
    end

endmodule

// File: tb/tb_rvfi_retire_seq.sv
// Directed plus randomised bench for rvfi_retire_seq with a retirement scoreboard.
// Latency: n/a.
// Backpressure: drives out_ready_i low/high/random to exercise head stalls.
module tb_rvfi_retire_seq;
    import tracer_pkg::*;

    localparam int Depth = 16;
    localparam int RecW  = 256;
    localparam int CmtW  = 128;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic [1:0]      iss_valid_i, iss_is_ex_i;
    logic [4:0]      iss_pl0_i, iss_pl1_i;
    logic [RecW-1:0] iss_rec0_i, iss_rec1_i;
    logic            iss_ready_o;
    logic [1:0]      cmt_cnt_i;
    logic [4:0]      cmt_pl0_i, cmt_pl1_i;
    logic [CmtW-1:0] cmt_data0_i, cmt_data1_i;
    logic            out_valid_o, out_ready_i;
    logic [RecW-1:0] out_rec_o;
    logic [CmtW-1:0] out_cmt_o;
    logic            mismatch_o;
    logic [1:0]      err_o;

    rvfi_retire_seq #(.Depth(Depth), .RecW(RecW), .CmtW(CmtW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .iss_valid_i(iss_valid_i), .iss_is_ex_i(iss_is_ex_i),
        .iss_pl0_i(iss_pl0_i), .iss_pl1_i(iss_pl1_i),
        .iss_rec0_i(iss_rec0_i), .iss_rec1_i(iss_rec1_i), .iss_ready_o(iss_ready_o),
        .cmt_cnt_i(cmt_cnt_i), .cmt_pl0_i(cmt_pl0_i), .cmt_pl1_i(cmt_pl1_i),
        .cmt_data0_i(cmt_data0_i), .cmt_data1_i(cmt_data1_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_rec_o(out_rec_o), .out_cmt_o(out_cmt_o),
        .mismatch_o(mismatch_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [RecW-1:0] rec;
        logic [CmtW-1:0] cmt;
    } exp_t;

    exp_t            sb_q[$];   // expected retirements, in issue order
    logic [RecW-1:0] exq_m[$];  // EX records not yet committed, in issue order
    int checks   = 0;
    int failures = 0;

    function automatic logic [4:0] pl_of(input logic [RecW-1:0] r);
        logic [7:0] b;
        b = r[7:0];
        return 5'(1) << (b % 8'd5);
    endfunction

    function automatic logic [CmtW-1:0] cmt_of(input logic [RecW-1:0] r);
        return {~r[63:0], r[63:0]};
    endfunction

    task automatic chk(input string tag, input logic [RecW-1:0] obs, input logic [RecW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Retirement monitor: inputs only change at posedge+2, so the negedge
    // view of valid & ready is exactly what the next posedge will retire.
    always @(negedge clk_i) begin
        if (!rst_ni && out_valid_o && out_ready_i) begin
            chk("sb_has_entry", RecW'(sb_q.size() != 0), RecW'(1));
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("retire_rec", out_rec_o, e.rec);
                chk("retire_cmt", RecW'(out_cmt_o), RecW'(e.cmt));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle();
        flush_i     = 1'b0;
        iss_valid_i = '0;
        iss_is_ex_i = '0;
        iss_pl0_i   = '0;
        iss_pl1_i   = '0;
        iss_rec0_i  = '0;
        iss_rec1_i  = '0;
        cmt_cnt_i   = '0;
        cmt_pl0_i   = '0;
        cmt_pl1_i   = '0;
        cmt_data0_i = '0;
        cmt_data1_i = '0;
    endtask

    task automatic expect_entry(input logic [RecW-1:0] r, input logic e);
        exp_t x;
        x.rec = r;
        x.cmt = e ? cmt_of(r) : CmtW'(0);
        sb_q.push_back(x);
        if (e) exq_m.push_back(r);
    endtask

    task automatic drive_push(input logic v0, input logic e0, input logic [RecW-1:0] r0,
                              input logic v1, input logic e1, input logic [RecW-1:0] r1,
                              input bit acc);
        iss_valid_i = {v1, v0};
        iss_is_ex_i = {e1, e0};
        iss_rec0_i  = r0;
        iss_rec1_i  = r1;
        iss_pl0_i   = pl_of(r0);
        iss_pl1_i   = pl_of(r1);
        if (acc) begin
            if (v0) expect_entry(r0, e0);
            if (v1) expect_entry(r1, e1);
        end
    endtask

    task automatic drive_commit(input int n, input bit bad1);
        int k;
        logic [RecW-1:0] r;
        logic [4:0] p;
        k = (n < exq_m.size()) ? n : exq_m.size();
        cmt_cnt_i   = 2'(n);
        cmt_pl0_i   = '0;
        cmt_pl1_i   = '0;
        cmt_data0_i = '0;
        cmt_data1_i = '0;
        if (k >= 1) begin
            r = exq_m.pop_front();
            cmt_pl0_i   = pl_of(r);
            cmt_data0_i = cmt_of(r);
        end
        if (k >= 2) begin
            r = exq_m.pop_front();
            p = pl_of(r);
            cmt_pl1_i   = bad1 ? {p[3:0], p[4]} : p;
            cmt_data1_i = cmt_of(r);
        end
    endtask

    task automatic do_reset();
        rst_ni      = 1'b1;
        out_ready_i = 1'b0;
        idle();
        sb_q.delete();
        exq_m.delete();
        tick();
        tick();
        rst_ni = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed, cyc, nc, lanes;

        // ---- reset ----
        rst_ni      = 1'b1;
        out_ready_i = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_iss_ready", iss_ready_o, 1);
        chk("rst_err", err_o, 0);
        chk("rst_mismatch", mismatch_o, 0);
        rst_ni = 1'b0;
        tick();
        chk("post_rst_out_valid", out_valid_o, 0);
        chk("post_rst_iss_ready", iss_ready_o, 1);

        // ---- non-EX then EX, EX waits for its commit ----
        out_ready_i = 1'b1;
        drive_push(1, 0, RecW'('hA), 1, 1, RecW'('hB), 1);
        tick();
        idle();
        chk("a_valid", out_valid_o, 1);
        chk("a_rec", out_rec_o, RecW'('hA));
        chk("a_cmt_zero", RecW'(out_cmt_o), 0);
        tick();
        chk("b_stall0", out_valid_o, 0);
        tick();
        chk("b_stall1", out_valid_o, 0);
        drive_commit(1, 0);
        #1;
        chk("b_no_bypass", out_valid_o, 0);
        tick();
        idle();
        chk("b_valid", out_valid_o, 1);
        chk("b_rec", out_rec_o, RecW'('hB));
        chk("b_cmt", RecW'(out_cmt_o), RecW'(cmt_of(RecW'('hB))));
        tick();
        chk("b_retired", out_valid_o, 0);
        chk("b_sb_empty", sb_q.size(), 0);

        // ---- pl mismatch on commit slot 1, stall stability ----
        do_reset();
        drive_push(1, 1, RecW'('h41), 1, 1, RecW'('h42), 1);
        tick();
        drive_push(1, 1, RecW'('h43), 0, 0, '0, 1);
        tick();
        idle();
        drive_commit(2, 1);
        tick();
        idle();
        chk("mm_pulse", mismatch_o, 1);
        chk("mm_head_valid", out_valid_o, 1);
        chk("mm_head_rec", out_rec_o, RecW'('h41));
        tick();
        chk("mm_pulse_end", mismatch_o, 0);
        chk("mm_stall_rec", out_rec_o, RecW'('h41));
        chk("mm_stall_cmt", RecW'(out_cmt_o), RecW'(cmt_of(RecW'('h41))));
        drive_commit(1, 0);
        out_ready_i = 1'b1;
        tick();
        idle();
        repeat (4) tick();
        chk("mm_sb_empty", sb_q.size(), 0);
        chk("mm_no_err", err_o, 0);
        chk("mm_quiet", mismatch_o, 0);

        // ---- commit underflow ----
        do_reset();
        drive_push(1, 1, RecW'('h51), 0, 0, '0, 1);
        tick();
        idle();
        drive_commit(2, 0);
        tick();
        idle();
        chk("udf_err", err_o, 2'b10);
        chk("udf_done", out_valid_o, 1);
        chk("udf_cmt", RecW'(out_cmt_o), RecW'(cmt_of(RecW'('h51))));
        out_ready_i = 1'b1;
        tick();
        tick();
        chk("udf_sb_empty", sb_q.size(), 0);

        // ---- fill to Depth, overflow drop ----
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive_push(1, 0, RecW'(32'h100 + 2 * i), 1, 0, RecW'(32'h101 + 2 * i), 1);
            tick();
        end
        idle();
        chk("ready_at_14", iss_ready_o, 1);
        drive_push(1, 0, RecW'('h10E), 1, 0, RecW'('h10F), 1);
        tick();
        idle();
        chk("ready_at_16", iss_ready_o, 0);
        drive_push(1, 0, RecW'('hBAD), 0, 0, '0, 0);
        tick();
        idle();
        chk("ovf_err", err_o, 2'b01);
        out_ready_i = 1'b1;
        tick();
        chk("ready_at_15", iss_ready_o, 0);
        tick();
        chk("ready_at_14b", iss_ready_o, 1);
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        tick();
        chk("fill_drained", sb_q.size(), 0);
        chk("fill_empty", out_valid_o, 0);

        // ---- flush with simultaneous push and commit ----
        do_reset();
        drive_push(1, 0, RecW'('h62), 1, 1, RecW'('h61), 1);
        tick();
        drive_push(1, 1, RecW'('h63), 1, 1, RecW'('h64), 1);
        tick();
        drive_push(1, 0, RecW'('h65), 0, 0, '0, 1);
        tick();
        idle();
        chk("pre_flush_valid", out_valid_o, 1);
        flush_i     = 1'b1;
        out_ready_i = 1'b1;
        drive_commit(2, 0);
        drive_push(1, 0, RecW'('h66), 1, 1, RecW'('h67), 0);
        #1;
        chk("flush_masks_valid", out_valid_o, 0);
        tick();
        idle();
        out_ready_i = 1'b0;
        sb_q.delete();
        exq_m.delete();
        chk("flush_valid", out_valid_o, 0);
        chk("flush_err", err_o, 0);
        chk("flush_ready", iss_ready_o, 1);
        drive_push(1, 0, RecW'('h68), 0, 0, '0, 1);
        tick();
        idle();
        chk("post_flush_valid", out_valid_o, 1);
        chk("post_flush_rec", out_rec_o, RecW'('h68));
        out_ready_i = 1'b1;
        tick();
        tick();
        chk("post_flush_sb_empty", sb_q.size(), 0);

        // ---- 40 mixed entries, random backpressure, pointer wrap ----
        do_reset();
        pushed = 0;
        cyc    = 0;
        while ((pushed < 40 || sb_q.size() != 0) && cyc < 3000) begin
            out_ready_i = 1'($urandom_range(0, 1));
            nc = $urandom_range(0, 2);
            if (nc > exq_m.size()) nc = exq_m.size();
            drive_commit(nc, 0);
            if (pushed < 40 && iss_ready_o) begin
                lanes = (pushed == 39) ? 1 : $urandom_range(1, 3);
                drive_push(lanes[0], 1'($urandom_range(0, 1)), RecW'(32'h1000 + pushed),
                           lanes[1], 1'($urandom_range(0, 1)),
                           RecW'(32'h1000 + pushed + int'(lanes[0])), 1);
                pushed += int'(lanes[0]) + int'(lanes[1]);
            end
            tick();
            idle();
            cyc++;
        end
        chk("rand_in_budget", cyc < 3000, 1);
        chk("rand_drained", sb_q.size(), 0);
        chk("rand_pushed", pushed, 40);
        chk("rand_no_err", err_o, 0);
        chk("rand_empty", out_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
